// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control block: FSM state encoding,
// digit width, per-digit moduli and the BCD next-value helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } state_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 6;

    localparam int CS_U_MOD  = 10;
    localparam int CS_T_MOD  = 10;
    localparam int SEC_U_MOD = 10;
    localparam int SEC_T_MOD = 6;
    localparam int MIN_U_MOD = 10;
    localparam int MIN_T_MOD = 10;

    // Digit index 0 is hundredths units, index 5 is tens of minutes.
    function automatic int digit_mod(input int idx);
        case (idx)
            0:       return CS_U_MOD;
            1:       return CS_T_MOD;
            2:       return SEC_U_MOD;
            3:       return SEC_T_MOD;
            4:       return MIN_U_MOD;
            default: return MIN_T_MOD;
        endcase
    endfunction

    function automatic logic [DIGIT_W-1:0] bcd_next(
        input logic [DIGIT_W-1:0] q,
        input logic               inc,
        input logic               clear,
        input int                 md
    );
        if (clear)
            return '0;
        if (!inc)
            return q;
        if (q == DIGIT_W'(md - 1))
            return '0;
        return q + 1'b1;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_digit.sv
// One BCD counter digit with modulus MOD; clear has priority over increment and
// carry flags the increment that rolls the digit back to zero.
module stopwatch_bcd_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               inc,
    output logic [DIGIT_W-1:0] q,
    output logic               carry
);

    logic [DIGIT_W-1:0] q_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q_reg <= '0;
        else
            q_reg <= bcd_next(q_reg, inc, clear, MOD);
    end

    assign q     = q_reg;
    assign carry = inc && (q_reg == DIGIT_W'(MOD - 1));

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch control: four-state FSM, six-digit BCD MM:SS.cc count advanced by the
// 100 Hz tick, lap latch and display mux that freezes the shown value in LAP.
module stopwatch_control
    import stopwatch_pkg::*;
#(
    parameter int MIN_MAX = 59
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tick_en,
    input  logic               start_stop,
    input  logic               lap_reset,
    output logic [DIGIT_W-1:0] min_t,
    output logic [DIGIT_W-1:0] min_u,
    output logic [DIGIT_W-1:0] sec_t,
    output logic [DIGIT_W-1:0] sec_u,
    output logic [DIGIT_W-1:0] cs_t,
    output logic [DIGIT_W-1:0] cs_u,
    output logic               running,
    output logic               lap_hold,
    output logic               wrap
);

    localparam logic [DIGIT_W-1:0] MIN_MAX_T = DIGIT_W'(MIN_MAX / 10);
    localparam logic [DIGIT_W-1:0] MIN_MAX_U = DIGIT_W'(MIN_MAX % 10);

    state_t state_reg, state_next;
    logic   count_clear, lap_load, count_en, min_wrap, wrap_reg;

    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] live_q;
    logic [NUM_DIGITS-1:0][DIGIT_W-1:0] disp_q;
    logic [NUM_DIGITS-1:0]              digit_inc;
    logic [NUM_DIGITS-1:0]              digit_clear;
    logic [NUM_DIGITS-1:0]              digit_carry;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    // start_stop is checked first in every state, so it wins a same-cycle collision.
    always_comb begin
        state_next  = state_reg;
        count_clear = 1'b0;
        lap_load    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_stop)
                    state_next = ST_RUN;
                else if (lap_reset)
                    count_clear = 1'b1;
            end
            ST_RUN: begin
                if (start_stop)
                    state_next = ST_PAUSE;
                else if (lap_reset) begin
                    state_next = ST_LAP;
                    lap_load   = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_stop)
                    state_next = ST_PAUSE;
                else if (lap_reset)
                    state_next = ST_RUN;
            end
            ST_PAUSE: begin
                if (start_stop)
                    state_next = ST_RUN;
                else if (lap_reset) begin
                    state_next  = ST_IDLE;
                    count_clear = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign running  = (state_reg == ST_RUN) || (state_reg == ST_LAP);
    assign lap_hold = (state_reg == ST_LAP);
    assign count_en = tick_en && running;

    // Seconds roll over while minutes sit at MIN_MAX; a 99 rollover of the pair also wraps.
    assign min_wrap = (digit_carry[3] && (live_q[4] == MIN_MAX_U) && (live_q[5] == MIN_MAX_T))
                      || digit_carry[5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wrap_reg <= 1'b0;
        else
            wrap_reg <= min_wrap;
    end

    assign wrap = wrap_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [DIGIT_W-1:0] lap_reg;

            if (gi == 0) begin : g_inc_tick
                assign digit_inc[gi] = count_en;
            end else begin : g_inc_carry
                assign digit_inc[gi] = digit_carry[gi-1];
            end

            if (gi < 4) begin : g_clr_sec
                assign digit_clear[gi] = count_clear;
            end else begin : g_clr_min
                assign digit_clear[gi] = count_clear || min_wrap;
            end

            stopwatch_bcd_digit #(
                .MOD (digit_mod(gi))
            ) u_digit (
                .clk   (clk),
                .reset (reset),
                .clear (digit_clear[gi]),
                .inc   (digit_inc[gi]),
                .q     (live_q[gi]),
                .carry (digit_carry[gi])
            );

            // Capture the value the live digit takes at this same edge, tick included.
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    lap_reg <= '0;
                else if (lap_load)
                    lap_reg <= bcd_next(live_q[gi], digit_inc[gi], digit_clear[gi], digit_mod(gi));
            end

            assign disp_q[gi] = lap_hold ? lap_reg : live_q[gi];
        end
    endgenerate

    assign cs_u  = disp_q[0];
    assign cs_t  = disp_q[1];
    assign sec_u = disp_q[2];
    assign sec_t = disp_q[3];
    assign min_u = disp_q[4];
    assign min_t = disp_q[5];

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: expected display/status words are queued as stimulus
// is driven and popped against the DUT one cycle later.
module tb_stopwatch_control;

    localparam int MIN_MAX = 10;
    localparam int WRAP_CS = (MIN_MAX + 1) * 6000;

    logic       clk = 1'b0;
    logic       reset, tick_en, start_stop, lap_reset;
    logic [3:0] min_t, min_u, sec_t, sec_u, cs_t, cs_u;
    logic       running, lap_hold, wrap;

    typedef struct packed {
        logic [23:0] disp;
        logic        running;
        logic        lap_hold;
        logic        wrap;
    } obs_t;

    obs_t dut_obs;
    obs_t exp_obs;
    obs_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   live_cs = 0;

    stopwatch_control #(.MIN_MAX(MIN_MAX)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .start_stop (start_stop),
        .lap_reset  (lap_reset),
        .min_t      (min_t),
        .min_u      (min_u),
        .sec_t      (sec_t),
        .sec_u      (sec_u),
        .cs_t       (cs_t),
        .cs_u       (cs_u),
        .running    (running),
        .lap_hold   (lap_hold),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    assign dut_obs = {min_t, min_u, sec_t, sec_u, cs_t, cs_u, running, lap_hold, wrap};

    function automatic obs_t mk(input int cs, input logic r, input logic l, input logic w);
        int m, s, c;
        obs_t o;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        o.disp     = {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
        o.running  = r;
        o.lap_hold = l;
        o.wrap     = w;
        return o;
    endfunction

    task automatic cycle(input logic ss, input logic lr, input logic tk);
        start_stop = ss;
        lap_reset  = lr;
        tick_en    = tk;
        @(posedge clk);
        #1;
        start_stop = 1'b0;
        lap_reset  = 1'b0;
        tick_en    = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick_en = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        tick_en = 1'b0;
        live_cs = (live_cs + n) % WRAP_CS;
    endtask

    task automatic test_reset();
        reset = 1'b1; tick_en = 1'b0; start_stop = 1'b0; lap_reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk(0, 0, 0, 0));
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL reset_values: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        reset = 1'b0;
        live_cs = 0;
        sb.push_back(mk(0, 0, 0, 0));
        ticks(150);
        live_cs = 0;
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL idle_ticks: got %h expected %h", dut_obs, exp_obs); else n_pass++;
    endtask

    task automatic test_run_pause();
        sb.push_back(mk(0, 1, 0, 0));
        cycle(1, 0, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL start: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        ticks(1234);
        sb.push_back(mk(live_cs, 0, 0, 0));
        cycle(1, 0, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL stop_at_12_34: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        sb.push_back(mk(live_cs, 0, 0, 0));
        tick_en = 1'b1;
        repeat (50) @(posedge clk);
        #1; tick_en = 1'b0;
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL paused_hold: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        live_cs = 0;
        sb.push_back(mk(0, 0, 0, 0));
        cycle(0, 1, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL pause_clear: got %h expected %h", dut_obs, exp_obs); else n_pass++;
    endtask

    task automatic test_tick_edges();
        sb.push_back(mk(0, 1, 0, 0));
        cycle(1, 0, 1);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL idle_tick_ignored: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        ticks(10);
        live_cs = live_cs + 1;
        sb.push_back(mk(live_cs, 0, 0, 0));
        cycle(1, 0, 1);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL stop_tick_counted: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        sb.push_back(mk(live_cs, 1, 0, 0));
        cycle(1, 0, 1);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL resume_tick_dropped: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        ticks(5);
        cycle(1, 0, 0);
        live_cs = 0;
        sb.push_back(mk(0, 0, 0, 0));
        cycle(0, 1, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL edges_clear: got %h expected %h", dut_obs, exp_obs); else n_pass++;
    endtask

    task automatic test_lap();
        int lap_cs;
        cycle(1, 0, 0);
        ticks(499);
        live_cs = live_cs + 1;
        lap_cs  = live_cs;
        sb.push_back(mk(lap_cs, 1, 1, 0));
        cycle(0, 1, 1);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL lap_capture: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        sb.push_back(mk(lap_cs, 1, 1, 0));
        ticks(300);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL lap_frozen: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        sb.push_back(mk(live_cs, 1, 0, 0));
        cycle(0, 1, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL lap_release: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        cycle(0, 1, 0);
        lap_cs = live_cs;
        sb.push_back(mk(lap_cs, 1, 1, 0));
        ticks(100);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL lap_again: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        sb.push_back(mk(live_cs, 0, 0, 0));
        cycle(1, 0, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL lap_to_pause: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        cycle(0, 1, 0);
        live_cs = 0;
    endtask

    task automatic test_same_cycle();
        cycle(1, 0, 0);
        ticks(200);
        sb.push_back(mk(live_cs, 0, 0, 0));
        cycle(1, 1, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL both_pulses: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        live_cs = 0;
        sb.push_back(mk(0, 0, 0, 0));
        cycle(0, 1, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL then_lap_reset: got %h expected %h", dut_obs, exp_obs); else n_pass++;
    endtask

    task automatic test_wrap();
        cycle(1, 0, 0);
        ticks(59999);
        sb.push_back(mk(live_cs, 1, 0, 0));
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL at_09_59_99: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        ticks(1);
        sb.push_back(mk(live_cs, 1, 0, 0));
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL minute_tens_carry: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        ticks(5999);
        sb.push_back(mk(live_cs, 1, 0, 0));
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL at_max: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        ticks(1);
        sb.push_back(mk(live_cs, 1, 0, 1));
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL wrap_pulse: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        sb.push_back(mk(live_cs, 1, 0, 0));
        cycle(0, 0, 0);
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL wrap_one_cycle: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        ticks(1);
        sb.push_back(mk(live_cs, 1, 0, 0));
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL after_wrap: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        cycle(1, 0, 0);
        cycle(0, 1, 0);
        live_cs = 0;
    endtask

    task automatic test_reset_midrun();
        cycle(1, 0, 0);
        ticks(8107);
        sb.push_back(mk(live_cs, 1, 0, 0));
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL midrun_01_21_07: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        #2;
        reset = 1'b1;
        live_cs = 0;
        sb.push_back(mk(0, 0, 0, 0));
        #1;
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL async_reset: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.push_back(mk(0, 0, 0, 0));
        ticks(20);
        live_cs = 0;
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL post_reset_ticks: got %h expected %h", dut_obs, exp_obs); else n_pass++;
        cycle(1, 0, 0);
        ticks(3);
        sb.push_back(mk(live_cs, 1, 0, 0));
        exp_obs = sb.pop_front(); n_total++;
        if (dut_obs !== exp_obs) $display("FAIL restart: got %h expected %h", dut_obs, exp_obs); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_run_pause();
        test_tick_edges();
        test_lap();
        test_same_cycle();
        test_wrap();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
